ring_osc_ctrl: RTL and testbench



---
 rtl/ring_osc_ctrl_pkg.sv | 21 ++
 rtl/ring_edge_sync.sv | 29 ++
 rtl/ring_osc_ctrl.sv | 159 +++++++++++++++
 tb/tb_ring_osc_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_ctrl_pkg.sv
// Shared types and default sizing for the ring oscillator sequencer.
// Imported by the top level and the edge synchroniser.
package ring_osc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        MEASURE,
        DONE
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int GATE_W_DEF      = 16;
    localparam int SETTLE_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Synchronises the asynchronous ring output into clk and
// emits a one-cycle pulse on each synchronised rising edge.
module ring_edge_sync
    import ring_osc_ctrl_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/ring_osc_ctrl.sv
// Ring oscillator sequencer: start, settle, then count ring edges
// over a programmable gate of clk cycles and publish the result.
module ring_osc_ctrl
    import ring_osc_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cont,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ring_clk,
    output logic              ring_rst_n,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam int TW = max_i(GATE_W, $clog2(SETTLE + 1));

    state_e             r_state;
    logic [TW-1:0]      r_tmr;
    logic [GATE_W-1:0]  r_gate;
    logic [CNT_W-1:0]   r_acc;
    logic               r_acc_ovf;

    logic               w_rise;
    logic               w_go;
    logic               w_tmr_zero;
    logic [TW-1:0]      w_rgate_m1;
    logic [TW-1:0]      w_igate_m1;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;

    ring_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ring_clk),
        .o_rise  (w_rise)
    );

    assign w_go       = start & ~abort;
    assign w_tmr_zero = (r_tmr == '0);
    assign w_rgate_m1 = TW'(r_gate) - TW'(1);
    assign w_igate_m1 = TW'(gate_len) - TW'(1);

    // Saturating accumulate; an edge at all-ones only flags overflow
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_acc_ovf;
        if (w_rise) begin
            if (&r_acc) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = r_acc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tmr      <= '0;
            r_gate     <= '0;
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            ring_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state    <= IDLE;
                ring_rst_n <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_go) begin
                            r_state    <= WARMUP;
                            r_tmr      <= TW'(SETTLE - 1);
                            r_gate     <= gate_len;
                            ring_rst_n <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    WARMUP: begin
                        if (!w_tmr_zero) begin
                            r_tmr <= r_tmr - TW'(1);
                        end else if (r_gate == '0) begin
                            r_state   <= DONE;
                            r_acc     <= '0;
                            r_acc_ovf <= 1'b0;
                            done      <= 1'b1;
                            count     <= '0;
                            ovf       <= 1'b0;
                            busy      <= cont;
                        end else begin
                            r_state   <= MEASURE;
                            r_tmr     <= w_rgate_m1;
                            r_acc     <= '0;
                            r_acc_ovf <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        r_acc     <= w_acc_nxt;
                        r_acc_ovf <= w_ovf_nxt;
                        if (w_tmr_zero) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            count   <= w_acc_nxt;
                            ovf     <= w_ovf_nxt;
                            busy    <= cont;
                        end else begin
                            r_tmr <= r_tmr - TW'(1);
                        end
                    end
                    DONE: begin
                        // Back-to-back mode keeps the ring running
                        if (!cont) begin
                            r_state    <= IDLE;
                            ring_rst_n <= 1'b0;
                            busy       <= 1'b0;
                        end else if (gate_len == '0) begin
                            r_gate    <= gate_len;
                            r_acc     <= '0;
                            r_acc_ovf <= 1'b0;
                            done      <= 1'b1;
                            count     <= '0;
                            ovf       <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            r_state   <= MEASURE;
                            r_gate    <= gate_len;
                            r_tmr     <= w_igate_m1;
                            r_acc     <= '0;
                            r_acc_ovf <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Bench for ring_osc_ctrl: directed table, corner sequences and
// randomized runs against an edge-list reference model.
module tb_ring_osc_ctrl;

    localparam int CW = 6;
    localparam int GW = 16;
    localparam int ST = 32;
    localparam int SS = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cont = 1'b0;
    logic [GW-1:0] gate_len = '0;
    logic          ring_clk = 1'b0;
    logic          ring_rst_n;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int per = 10;
    int ph = 0;
    int rises[$];
    int last_c = 0;
    int last_o = 0;

    typedef struct {
        int g;
        int p;
        int ec;
        int eo;
        bit poke;
    } vec_t;

    vec_t tbl[5];

    ring_osc_ctrl #(
        .CNT_W       (CW),
        .GATE_W      (GW),
        .SETTLE      (ST),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cont       (cont),
        .gate_len   (gate_len),
        .ring_clk   (ring_clk),
        .ring_rst_n (ring_rst_n),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ring model: runs only while enabled, rises once per period
    always @(negedge clk) begin
        if (!ring_rst_n) begin
            ph = 0;
            ring_clk = 1'b0;
        end else begin
            ph = (ph + 1) % per;
            if (ph == per / 2) rises.push_back(cyc);
            ring_clk = (ph >= per / 2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Edges seen by the counter are those whose synchronised
    // pulse lands in one of the g gate cycles before done.
    function automatic int model_cnt(input int d, input int g);
        int n = 0;
        foreach (rises[i]) begin
            if (rises[i] + SS >= d - g && rises[i] + SS <= d - 1) n++;
        end
        return n;
    endfunction

    task automatic do_meas(input string nm, input int g, input int p,
                           input int ec, input int eo, input bit poke);
        int s;
        int d;
        int n;
        int viol = 0;
        per = p;
        gate_len = GW'(g);
        rises.delete();
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = s + 1 + ST + g;
        while (cyc < d) begin
            if (!busy || done || !ring_rst_n) viol++;
            if (poke && cyc == s + 10) begin
                start = 1'b1;
                gate_len = GW'(g + 7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n = model_cnt(d, g);
        chk({nm, " busy_window"}, viol, 0);
        chk({nm, " done"}, done, 1);
        chk({nm, " busy_in_done"}, busy, 0);
        chk({nm, " ring_in_done"}, ring_rst_n, 1);
        chk({nm, " count_model"}, count, (n > MAXC) ? MAXC : n);
        chk({nm, " ovf_model"}, ovf, (n > MAXC) ? 1 : 0);
        if (ec >= 0) begin
            chk({nm, " count_table"}, count, ec);
            chk({nm, " ovf_table"}, ovf, eo);
        end
        last_c = (n > MAXC) ? MAXC : n;
        last_o = (n > MAXC) ? 1 : 0;
        @(negedge clk);
        chk({nm, " ring_off"}, ring_rst_n, 0);
        chk({nm, " done_gone"}, done, 0);
        chk({nm, " idle_busy"}, busy, 0);
    endtask

    initial begin
        int s;
        int d;
        int n;
        int viol;
        tbl[0] = '{100, 10, 10, 0, 1'b0};
        tbl[1] = '{300, 4, MAXC, 1, 1'b0};
        tbl[2] = '{20, 4, 5, 0, 1'b1};
        tbl[3] = '{0, 7, 0, 0, 1'b0};
        tbl[4] = '{1, 3, 1, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst ring", ring_rst_n, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst count", count, 0);
        chk("rst ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_meas($sformatf("tbl%0d", i), tbl[i].g, tbl[i].p,
                    tbl[i].ec, tbl[i].eo, tbl[i].poke);
            repeat (3) @(negedge clk);
        end

        // Abort partway through the gate
        per = 10;
        gate_len = GW'(100);
        rises.delete();
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + ST + 50) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort ring", ring_rst_n, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort count", count, last_c);
        chk("abort ovf", ovf, last_o);
        viol = 0;
        repeat (150) begin
            if (done || busy || count != CW'(last_c)) viol++;
            @(negedge clk);
        end
        chk("abort quiet", viol, 0);
        do_meas("after_abort", 40, 8, -1, 0, 1'b0);

        // start with abort in IDLE
        @(negedge clk);
        gate_len = GW'(5);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        viol = 0;
        repeat (50) begin
            if (done || busy || ring_rst_n) viol++;
            @(negedge clk);
        end
        chk("start_abort idle", viol, 0);

        // Continuous mode
        per = 5;
        gate_len = GW'(50);
        cont = 1'b1;
        rises.delete();
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = s + 1 + ST + 50;
        for (int k = 0; k < 4; k++) begin
            viol = 0;
            while (cyc < d) begin
                if (!busy || done || !ring_rst_n) viol++;
                if (k == 3 && cyc == d - 40) cont = 1'b0;
                @(negedge clk);
            end
            n = model_cnt(d, 50);
            chk($sformatf("cont%0d gap", k), viol, 0);
            chk($sformatf("cont%0d done", k), done, 1);
            chk($sformatf("cont%0d count", k), count, 10);
            chk($sformatf("cont%0d model", k), count, n);
            chk($sformatf("cont%0d ring", k), ring_rst_n, 1);
            chk($sformatf("cont%0d busy", k), busy, (k == 3) ? 0 : 1);
            d = d + 51;
            @(negedge clk);
        end
        chk("cont end ring", ring_rst_n, 0);
        chk("cont end done", done, 0);
        last_c = 10;
        last_o = 0;

        // Asynchronous reset during WARMUP
        per = 6;
        gate_len = GW'(40);
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ring", ring_rst_n, 0);
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst count", count, 0);
        chk("arst ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (60) begin
            if (done || busy || ring_rst_n) viol++;
            @(negedge clk);
        end
        chk("arst idle", viol, 0);

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_meas("rand", $urandom_range(0, 90), $urandom_range(3, 12),
                    -1, 0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
